sram_req_arbiter: RTL and testbench
===================================

// Module: sram_req_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the IF stage (inst_sram_*, requester 0) and the
//  EXE/MEM stages (data_sram_*, requester 1). Issues requests in order and tracks outstanding
//  requests by requester ID. Routes each in-order data_ok/rdata back to its owner, which
//  drives the MEM stage's ready_go (data_sram_data_ok). Sits between the core and the AXI bridge.
// PARAMETERS
//  MAX_OUTSTANDING  2   max accepted-but-unanswered requests (power of 2, >=1)
//  CNT_W            2   width of outstanding counter = clog2(MAX_OUTSTANDING)+1
// PORTS
//  clk              in   1   core clock
//  reset            in   1   synchronous, active-high reset
//  inst_sram_req    in   1   IF request; held stable until inst_sram_addr_ok
//  inst_sram_wr     in   1   1=write (always 0 for IF in practice)
//  inst_sram_size   in   2   0=byte,1=half,2=word
//  inst_sram_wstrb  in   4   byte enables
//  inst_sram_addr   in   32  physical address
//  inst_sram_wdata  in   32  write data
//  inst_sram_addr_ok out 1   IF request accepted this cycle
//  inst_sram_data_ok out 1   IF response valid this cycle
//  inst_sram_rdata  out  32  IF read data
//  data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data-side, same semantics
//  data_sram_addr_ok out 1   data request accepted
//  data_sram_data_ok out 1   data response (read data or write done)
//  data_sram_rdata  out  32  data read data
//  mem_req/wr/size/wstrb/addr/wdata  out 1/1/2/4/32/32  shared port toward bridge
//  mem_addr_ok      in   1   shared port accepted request
//  mem_data_ok      in   1   shared port response, strictly in issue order
//  mem_rdata        in   32  shared port read data
// BEHAVIOUR
//  - Reset: grant lock cleared, FIFO empty, count=0; all *_addr_ok, *_data_ok, mem_req = 0
//    while reset is high and the cycle after.
//  - Issue gate: can_issue = (count < MAX_OUTSTANDING). A pop in the same cycle does NOT
//    free a slot for a same-cycle issue.
//  - Arbitration: states IDLE / LOCK_I / LOCK_D (registered lock).
//    IDLE: data_sram_req wins over inst_sram_req (fixed priority). If the winner is not
//    accepted (mem_addr_ok=0 or !can_issue), go to LOCK_<winner>.
//    LOCK_x: only x is forwarded, even if the other requester asserts. Return to IDLE on
//    the cycle mem_addr_ok=1 for x.
//  - mem_* = muxed fields of the granted requester; mem_req = granted_req & can_issue.
//  - Accept: mem_req & mem_addr_ok -> assert granted *_addr_ok (combinational, same cycle),
//    push requester ID into FIFO, count+1.
//  - Response: mem_data_ok pops FIFO head. head==0 -> inst_sram_data_ok=1; head==1 ->
//    data_sram_data_ok=1. Both rdata outputs = mem_rdata. Response latency is 0 cycles added.
//  - Simultaneous push and pop: count unchanged; FIFO head/tail both advance; wrap-around
//    modulo MAX_OUTSTANDING.
//  - mem_data_ok with count==0: protocol error; ignored (no data_ok out, count stays 0).
//    Bench flags it.
//  - Pipeline flush (exception, ertn, refetch) does not affect this block. Outstanding
//    responses are still delivered. The stages discard them.
//  - Reset mid-transaction: all tracking is dropped; the bridge is reset on the same reset.
// STRUCTURE
//  - Shared package sram_arb_pkg: REQ_ID_INST=1'b0, REQ_ID_DATA=1'b1, SIZE_* encodings,
//    arbiter state encodings.
//  - One sub-module: sram_id_fifo (1-bit wide, MAX_OUTSTANDING deep, push/pop/count/head).
//  - Top: lock FSM, field mux, response demux.
// TESTING
//  1. Reset held 3 cycles with both reqs=1 -> mem_req=0, all addr_ok/data_ok=0; first cycle
//     after reset deassert, mem_req=0.
//  2. Both reqs together, mem_addr_ok=1 -> data granted first (mem_addr=data_sram_addr);
//     next cycle inst granted; mem_data_ok x2 -> data_sram_data_ok then inst_sram_data_ok.
//  3. inst request alone with mem_addr_ok=0 for 3 cycles, data req rises in cycle 2 ->
//     mem_addr stays inst addr until accepted; data is issued the cycle after.
//  4. MAX_OUTSTANDING=2: two accepted reads with no data_ok -> mem_req=0 on the third
//     request. Same cycle as first data_ok -> still 0. Next cycle -> issued.
//  5. Push and pop in the same cycle, 8 reads back-to-back -> count stays constant, FIFO
//     wraps, rdata 0x1..0x8 each goes to the correct requester.
//  6. Stray mem_data_ok with count=0 -> no data_ok output, count=0; assertion fires.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared IDs, size encodings, arbiter states and request-field bundle for the SRAM request arbiter.
// Latency and backpressure are not applicable: this file holds types and constants only.
package sram_arb_pkg;

  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// One SRAM-like request/response port. The master issues req and fields; the slave answers.
// The request is held until addr_ok; responses come back as data_ok/rdata with no backpressure.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_id_fifo.sv
// In-order FIFO of 1-bit requester IDs that tracks outstanding requests.
// The head is registered and is valid while count is non-zero; the caller must gate push on full and pop on empty.
module sram_id_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] ids_q, ids_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      ids_d[wr_ptr_q] = push_id;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ids_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ids_q    <= ids_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_id = ids_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one memory port between the IF requester and the data requester using a fixed-priority arbiter with a grant lock.
// addr_ok and data_ok are combinational (0 added cycles); issue stalls when MAX_OUTSTANDING requests are unanswered.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_req_arbiter_if.slave    inst_sram,
  sram_req_arbiter_if.slave    data_sram,
  sram_req_arbiter_if.master   mem
);

  arb_state_e       state_q, state_d;
  logic             rst_dly_q, rst_dly_d;
  logic             blocked;
  logic             grant_id;
  logic             granted_req;
  logic             can_issue;
  logic             mem_req;
  logic             accept;
  logic             pop;
  logic             head_id;
  logic [CNT_W-1:0] outstanding;
  sram_req_t        inst_fields;
  sram_req_t        data_fields;
  sram_req_t        mem_fields;

  assign inst_fields = '{wr: inst_sram.wr, size: inst_sram.size, wstrb: inst_sram.wstrb,
                         addr: inst_sram.addr, wdata: inst_sram.wdata};
  assign data_fields = '{wr: data_sram.wr, size: data_sram.size, wstrb: data_sram.wstrb,
                         addr: data_sram.addr, wdata: data_sram.wdata};

  always_comb begin
    state_d   = state_q;
    rst_dly_d = reset;
    // Handshakes stay quiet during reset and for one cycle after it is released.
    blocked   = reset | rst_dly_q;
    can_issue = (outstanding < CNT_W'(MAX_OUTSTANDING));

    case (state_q)
      ARB_LOCK_I: grant_id = REQ_ID_INST;
      ARB_LOCK_D: grant_id = REQ_ID_DATA;
      default:    grant_id = data_sram.req ? REQ_ID_DATA : REQ_ID_INST;
    endcase

    granted_req = (grant_id == REQ_ID_DATA) ? data_sram.req : inst_sram.req;
    mem_fields  = (grant_id == REQ_ID_DATA) ? data_fields : inst_fields;
    mem_req     = granted_req & can_issue & ~blocked;
    accept      = mem_req & mem.addr_ok;
    pop         = mem.data_ok & (outstanding != '0) & ~blocked;

    case (state_q)
      ARB_IDLE: begin
        if (granted_req && !accept) begin
          state_d = (grant_id == REQ_ID_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
        end
      end
      ARB_LOCK_I, ARB_LOCK_D: begin
        if (accept) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
    rst_dly_q <= rst_dly_d;
  end

  sram_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (grant_id),
    .pop     (pop),
    .head_id (head_id),
    .count   (outstanding)
  );

  assign mem.req   = mem_req;
  assign mem.wr    = mem_fields.wr;
  assign mem.size  = mem_fields.size;
  assign mem.wstrb = mem_fields.wstrb;
  assign mem.addr  = mem_fields.addr;
  assign mem.wdata = mem_fields.wdata;

  assign inst_sram.addr_ok = accept & (grant_id == REQ_ID_INST);
  assign data_sram.addr_ok = accept & (grant_id == REQ_ID_DATA);
  assign inst_sram.data_ok = pop & (head_id == REQ_ID_INST);
  assign data_sram.data_ok = pop & (head_id == REQ_ID_DATA);
  assign inst_sram.rdata   = mem.rdata;
  assign data_sram.rdata   = mem.rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter: reset, priority, lock, outstanding limit, wrap, stray response.
module tb_sram_req_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if mem_if ();

  sram_req_arbiter #(.MAX_OUTSTANDING(2), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_sram (inst_if),
    .data_sram (data_if),
    .mem       (mem_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.wstrb = 4'hf;
    inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.wstrb = 4'hf;
    data_if.addr = 32'h0; data_if.wdata = 32'h0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
  endtask

  // Leaves the bench one cycle past the blocked post-reset cycle, inputs idle.
  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_if.req = 1'b1; data_if.req = 1'b1; mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      vec_cnt++; if (mem_if.req !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_req c%0d: got %b want 0", c, mem_if.req); end
      vec_cnt++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b00) begin err_cnt++; $display("FAIL reset_addr_ok c%0d: got %b want 00", c, {inst_if.addr_ok, data_if.addr_ok}); end
      vec_cnt++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin err_cnt++; $display("FAIL reset_data_ok c%0d: got %b want 00", c, {inst_if.data_ok, data_if.data_ok}); end
      step();
    end
    reset = 1'b0;
    #2;
    vec_cnt++; if (mem_if.req !== 1'b0) begin err_cnt++; $display("FAIL post_reset_mem_req: got %b want 0", mem_if.req); end
    vec_cnt++; if ({inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 4'b0000) begin err_cnt++; $display("FAIL post_reset_handshakes: got %b want 0000", {inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok}); end
    vec_cnt++; if (dut.outstanding !== 2'd0) begin err_cnt++; $display("FAIL post_reset_count: got %0d want 0", dut.outstanding); end
    apply_reset();
  endtask

  task automatic test_priority();
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_1000;
    data_if.req = 1'b1; data_if.addr = 32'h0000_2000; data_if.wr = 1'b1; data_if.wdata = 32'h0000_dead;
    mem_if.addr_ok = 1'b1;
    #2;
    vec_cnt++; if (mem_if.addr !== 32'h0000_2000) begin err_cnt++; $display("FAIL prio_first_addr: got %h want 00002000", mem_if.addr); end
    vec_cnt++; if ({mem_if.req, mem_if.wr, mem_if.wdata} !== {1'b1, 1'b1, 32'h0000_dead}) begin err_cnt++; $display("FAIL prio_first_fields: got %b %b %h want 1 1 0000dead", mem_if.req, mem_if.wr, mem_if.wdata); end
    vec_cnt++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01) begin err_cnt++; $display("FAIL prio_first_addr_ok: got %b want 01", {inst_if.addr_ok, data_if.addr_ok}); end
    step();
    data_if.req = 1'b0; data_if.wr = 1'b0;
    #2;
    vec_cnt++; if (mem_if.addr !== 32'h0000_1000) begin err_cnt++; $display("FAIL prio_second_addr: got %h want 00001000", mem_if.addr); end
    vec_cnt++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10) begin err_cnt++; $display("FAIL prio_second_addr_ok: got %b want 10", {inst_if.addr_ok, data_if.addr_ok}); end
    step();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'haaaa_0001;
    #2;
    vec_cnt++; if (dut.outstanding !== 2'd2) begin err_cnt++; $display("FAIL prio_count: got %0d want 2", dut.outstanding); end
    vec_cnt++; if ({inst_if.data_ok, data_if.data_ok, data_if.rdata} !== {2'b01, 32'haaaa_0001}) begin err_cnt++; $display("FAIL prio_resp0: got %b%b %h want 01 aaaa0001", inst_if.data_ok, data_if.data_ok, data_if.rdata); end
    step();
    mem_if.rdata = 32'hbbbb_0002;
    #2;
    vec_cnt++; if ({inst_if.data_ok, data_if.data_ok, inst_if.rdata} !== {2'b10, 32'hbbbb_0002}) begin err_cnt++; $display("FAIL prio_resp1: got %b%b %h want 10 bbbb0002", inst_if.data_ok, data_if.data_ok, inst_if.rdata); end
    step();
    mem_if.data_ok = 1'b0;
    #2;
    vec_cnt++; if (dut.outstanding !== 2'd0) begin err_cnt++; $display("FAIL prio_drained: got %0d want 0", dut.outstanding); end
    apply_reset();
  endtask

  task automatic test_lock();
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_3000;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin data_if.req = 1'b1; data_if.addr = 32'h0000_4000; end
      #2;
      vec_cnt++; if ({mem_if.req, mem_if.addr} !== {1'b1, 32'h0000_3000}) begin err_cnt++; $display("FAIL lock_hold c%0d: got %b %h want 1 00003000", c, mem_if.req, mem_if.addr); end
      vec_cnt++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b00) begin err_cnt++; $display("FAIL lock_no_accept c%0d: got %b want 00", c, {inst_if.addr_ok, data_if.addr_ok}); end
      step();
    end
    mem_if.addr_ok = 1'b1;
    #2;
    vec_cnt++; if ({mem_if.addr, inst_if.addr_ok, data_if.addr_ok} !== {32'h0000_3000, 2'b10}) begin err_cnt++; $display("FAIL lock_accept: got %h %b%b want 00003000 10", mem_if.addr, inst_if.addr_ok, data_if.addr_ok); end
    step();
    inst_if.req = 1'b0;
    #2;
    vec_cnt++; if ({mem_if.addr, inst_if.addr_ok, data_if.addr_ok} !== {32'h0000_4000, 2'b01}) begin err_cnt++; $display("FAIL lock_then_data: got %h %b%b want 00004000 01", mem_if.addr, inst_if.addr_ok, data_if.addr_ok); end
    apply_reset();
  endtask

  task automatic test_max_outstanding();
    data_if.req = 1'b1; mem_if.addr_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      data_if.addr = 32'h10 + 32'(4 * c);
      #2;
      vec_cnt++; if (data_if.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL max_fill%0d: got %b want 1", c, data_if.addr_ok); end
      step();
    end
    data_if.addr = 32'h18;
    #2;
    vec_cnt++; if ({mem_if.req, data_if.addr_ok} !== 2'b00) begin err_cnt++; $display("FAIL max_full_gate: got %b%b want 00", mem_if.req, data_if.addr_ok); end
    step();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h11;
    #2;
    vec_cnt++; if ({mem_if.req, data_if.data_ok} !== 2'b01) begin err_cnt++; $display("FAIL max_pop_no_issue: got req=%b data_ok=%b want 0 1", mem_if.req, data_if.data_ok); end
    step();
    mem_if.data_ok = 1'b0;
    #2;
    vec_cnt++; if ({mem_if.req, data_if.addr_ok, mem_if.addr} !== {2'b11, 32'h18}) begin err_cnt++; $display("FAIL max_reissue: got %b%b %h want 11 00000018", mem_if.req, data_if.addr_ok, mem_if.addr); end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ids;
    logic       want_i;
    logic       want_d;
    ids = 8'b1001_0110;
    for (int k = 0; k <= 8; k++) begin
      inst_if.req = 1'b0; data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      if (k < 8) begin
        mem_if.addr_ok = 1'b1;
        if (ids[k]) begin data_if.req = 1'b1; data_if.addr = 32'h100 + 32'(4 * k); end
        else        begin inst_if.req = 1'b1; inst_if.addr = 32'h100 + 32'(4 * k); end
      end
      mem_if.data_ok = (k > 0);
      mem_if.rdata   = 32'(k);
      #2;
      if (k < 8) begin
        vec_cnt++; if ({data_if.addr_ok, inst_if.addr_ok} !== {ids[k], ~ids[k]}) begin err_cnt++; $display("FAIL b2b_accept%0d: got d%b i%b want d%b", k, data_if.addr_ok, inst_if.addr_ok, ids[k]); end
      end
      if (k > 0) begin
        want_d = ids[k-1];
        want_i = ~ids[k-1];
        vec_cnt++; if ({inst_if.data_ok, data_if.data_ok} !== {want_i, want_d}) begin err_cnt++; $display("FAIL b2b_route%0d: got i%b d%b want i%b d%b", k, inst_if.data_ok, data_if.data_ok, want_i, want_d); end
        vec_cnt++; if (inst_if.rdata !== 32'(k)) begin err_cnt++; $display("FAIL b2b_rdata%0d: got %h want %h", k, inst_if.rdata, 32'(k)); end
        vec_cnt++; if (dut.outstanding !== 2'd1) begin err_cnt++; $display("FAIL b2b_count%0d: got %0d want 1", k, dut.outstanding); end
      end
      step();
    end
    clear_inputs();
    #2;
    vec_cnt++; if (dut.outstanding !== 2'd0) begin err_cnt++; $display("FAIL b2b_drained: got %0d want 0", dut.outstanding); end
    apply_reset();
  endtask

  task automatic test_stray_response();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'hffff_ffff;
    #2;
    if (mem_if.data_ok && dut.outstanding == 2'd0)
      $display("note: protocol error flagged, mem_data_ok with nothing outstanding");
    vec_cnt++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin err_cnt++; $display("FAIL stray_data_ok: got %b want 00", {inst_if.data_ok, data_if.data_ok}); end
    step();
    mem_if.data_ok = 1'b0;
    #2;
    vec_cnt++; if (dut.outstanding !== 2'd0) begin err_cnt++; $display("FAIL stray_count: got %0d want 0", dut.outstanding); end
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_5000; mem_if.addr_ok = 1'b1;
    #2;
    vec_cnt++; if (inst_if.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL stray_followup_accept: got %b want 1", inst_if.addr_ok); end
    step();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000_0055;
    #2;
    vec_cnt++; if ({inst_if.data_ok, data_if.data_ok, inst_if.rdata} !== {2'b10, 32'h55}) begin err_cnt++; $display("FAIL stray_followup_resp: got %b%b %h want 10 00000055", inst_if.data_ok, data_if.data_ok, inst_if.rdata); end
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_priority();
    test_lock();
    test_max_outstanding();
    test_back_to_back();
    test_stray_response();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
